lsu_apb_bridge: RTL
===================

Name: lsu_apb_bridge

Overview:
- Load/store unit between the RV32I single-cycle datapath's data-memory port and an APB data bus.
- Takes the datapath's ALU-computed data address, store data and the instruction funct3.
- Runs one APB transfer per load/store; stalls the core until the transfer completes.
- Returns byte/halfword/word load data already lane-aligned and sign/zero-extended, ready for the register write-data mux.

Parameters:
- TIMEOUT_CYCLES, 255: max ACCESS cycles with PREADY low before the transfer is aborted with error.
- ADDR_W, 32: APB address width; PADDR = req_addr[ADDR_W-1:2],2'b00.

Ports:
- clk  in  1  system clock, all flops on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- req_valid  in  1  current instruction is a load or store.
- req_we  in  1  1=store, 0=load.
- req_funct3  in  3  instr[14:12] width/sign code.
- req_addr  in  32  byte address (ALU result).
- req_wdata  in  32  store data (rs2).
- stall  out  1  hold PC and register-file write.
- rsp_valid  out  1  one-cycle pulse, result committed this cycle.
- rsp_rdata  out  32  extended load data, valid with rsp_valid.
- rsp_err  out  1  misaligned/illegal/slave-error/timeout, valid with rsp_valid.
- PADDR  out  ADDR_W  APB address.
- PSEL, PENABLE, PWRITE  out  1  APB control.
- PWDATA  out  32  APB write data.
- PSTRB  out  4  APB byte strobes.
- PRDATA  in  32  APB read data.
- PREADY, PSLVERR  in  1  APB response.

Behaviour:
- Reset (async, reset_n=0): state IDLE; all outputs 0; timeout counter 0. Asserting reset mid-transfer drops PSEL/PENABLE immediately.
- States: IDLE, SETUP, ACCESS, RESP.
- stall = req_valid & (state != RESP) (combinational).
- IDLE:
  - On req_valid, latch we/funct3/addr/wdata.
  - Legal and aligned -> SETUP; otherwise -> RESP with err=1, no APB transfer.
  - Without req_valid -> stay IDLE.
- Legal codes:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Any other code is illegal.
- Alignment: halfword requires addr[0]=0; word requires addr[1:0]=0.
- SETUP (1 cycle): PSEL=1, PENABLE=0, PADDR/PWRITE/PWDATA/PSTRB driven from latched values -> ACCESS.
- ACCESS: PSEL=1, PENABLE=1, all APB outputs held stable.
  - PREADY=1 -> RESP; capture PRDATA and PSLVERR.
  - PREADY=0 -> increment counter; when counter reaches TIMEOUT_CYCLES-1 with PREADY still 0 -> RESP with err=1, PSEL dropped.
- RESP (1 cycle):
  - rsp_valid=1, stall=0; the core commits its register write and PC update this cycle.
  - Next state IDLE; counter cleared.
  - rsp_rdata=0 whenever rsp_err=1 or the access is a store.
- Strobes (b = addr[1:0]): SB 4'b0001<<b; SH 4'b0011<<b; SW 4'b1111; loads 4'b0000.
- PWDATA: SB replicates byte {4{wdata[7:0]}}; SH {2{wdata[15:0]}}; SW wdata.
- Load data: s = PRDATA >> (8*b).
  - LB: sign-extend s[7:0]. LBU: zero-extend s[7:0].
  - LH: sign-extend s[15:0]. LHU: zero-extend s[15:0].
  - LW: PRDATA unchanged.
- Request inputs are ignored outside IDLE. If req_valid falls mid-transfer, the APB transfer still completes and RESP still pulses.
- Back-to-back: a new request is accepted in the IDLE cycle following RESP. Minimum occupancy is 4 cycles per access with a zero-wait slave.
- Outputs other than stall are registered or decoded from state and latched values.

Test Plan:
- SW addr=0x0000_1008, wdata=0xDEADBEEF, PREADY=1 -> SETUP cycle, then ACCESS with PADDR=0x1008, PSTRB=1111, PWRITE=1; rsp_valid on cycle 4, stall high cycles 1-3.
- SB addr=0x1003, wdata=0x000000A5 -> PADDR=0x1000, PSTRB=1000, PWDATA=0xA5A5A5A5, rsp_err=0.
- PRDATA=0x80FF7F01: LB@0x1001 -> 0x0000007F; LB@0x1002 -> 0xFFFFFFFF; LBU@0x1003 -> 0x00000080; LH@0x1002 -> 0xFFFF80FF; LHU@0x1000 -> 0x00007F01.
- LW@0x1002 and LH@0x1001 -> PSEL never asserted, RESP on cycle 2, rsp_err=1, rsp_rdata=0. Same result for funct3=011 load.
- PREADY low for 3 cycles then high with PSLVERR=1 -> ACCESS lasts 4 cycles, rsp_err=1. With PREADY held low and TIMEOUT_CYCLES=8 -> abort after 8 ACCESS cycles, rsp_err=1, PSEL drops.
- reset_n pulsed low during ACCESS -> PSEL/PENABLE/stall/rsp_valid go 0 immediately. After release, a fresh LW@0x2000 completes normally.

Source files
------------

// File: rtl/lsu_apb_bridge.sv
// Load/store unit bridging the RV32I data-memory port onto an APB data bus.
// Latency: 4 cycles per access with a zero-wait slave (IDLE, SETUP, ACCESS, RESP); 2 cycles for rejected requests.
// Backpressure: stall holds the core until the RESP cycle; PREADY wait states extend ACCESS up to TIMEOUT_CYCLES.
//
// Ports:
//   clk, reset_n                       clock, async active-low reset
//   req_valid/req_we/req_funct3        load/store request from the datapath
//   req_addr/req_wdata                 byte address and store data (rs2)
//   stall                              hold PC and register-file write
//   rsp_valid/rsp_rdata/rsp_err        one-cycle commit pulse with extended load data / error
//   PADDR..PSTRB, PRDATA/PREADY/PSLVERR APB requester interface
module lsu_apb_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned ADDR_W         = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              stall,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] PADDR,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [31:0]       PWDATA,
  output logic [3:0]        PSTRB,
  input  logic [31:0]       PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR
);

  // Counter only ever needs to hold 0..TIMEOUT_CYCLES-1.
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t             state_q, state_d;
  logic               we_q, we_d;
  logic [2:0]         f3_q, f3_d;
  logic [31:0]        addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               req_ok;

  // Lane-align and extend the read word according to width/sign code.
  function automatic logic [31:0] load_ext(input logic [2:0] f3,
                                           input logic [1:0] b,
                                           input logic [31:0] d);
    logic [31:0] s;
    s = d >> {b, 3'b000};
    case (f3)
      3'b000:  load_ext = {{24{s[7]}}, s[7:0]};
      3'b001:  load_ext = {{16{s[15]}}, s[15:0]};
      3'b100:  load_ext = {24'h0, s[7:0]};
      3'b101:  load_ext = {16'h0, s[15:0]};
      default: load_ext = d;
    endcase
  endfunction

  // Legal code and natural alignment check on the incoming request.
  always_comb begin
    req_ok = 1'b0;
    case (req_funct3)
      3'b000:  req_ok = 1'b1;
      3'b001:  req_ok = ~req_addr[0];
      3'b010:  req_ok = (req_addr[1:0] == 2'b00);
      3'b100:  req_ok = ~req_we;
      3'b101:  req_ok = ~req_we & ~req_addr[0];
      default: req_ok = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      f3_q    <= 3'b000;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    f3_d    = f3_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (req_valid) begin
          we_d    = req_we;
          f3_d    = req_funct3;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          rdata_d = 32'h0;
          err_d   = ~req_ok;
          // Rejected requests skip the bus entirely and answer next cycle.
          state_d = req_ok ? SETUP : RESP;
        end
      end
      SETUP: begin
        cnt_d   = '0;
        state_d = ACCESS;
      end
      ACCESS: begin
        if (PREADY) begin
          state_d = RESP;
          err_d   = PSLVERR;
          rdata_d = (PSLVERR || we_q) ? 32'h0 : load_ext(f3_q, addr_q[1:0], PRDATA);
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_d = RESP;
          err_d   = 1'b1;
          rdata_d = 32'h0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset forces stall low even if the core keeps req_valid asserted.
  assign stall     = reset_n & req_valid & (state_q != RESP);
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = (state_q == RESP) ? rdata_q : 32'h0;
  assign rsp_err   = (state_q == RESP) & err_q;

  assign PSEL    = (state_q == SETUP) || (state_q == ACCESS);
  assign PENABLE = (state_q == ACCESS);
  assign PADDR   = {addr_q[ADDR_W-1:2], 2'b00};
  assign PWRITE  = we_q;

  always_comb begin
    PSTRB  = 4'b0000;
    PWDATA = 32'h0;
    if (we_q) begin
      case (f3_q)
        3'b000: begin
          PSTRB  = 4'b0001 << addr_q[1:0];
          PWDATA = {4{wdata_q[7:0]}};
        end
        3'b001: begin
          PSTRB  = 4'b0011 << addr_q[1:0];
          PWDATA = {2{wdata_q[15:0]}};
        end
        3'b010: begin
          PSTRB  = 4'b1111;
          PWDATA = wdata_q;
        end
        default: begin
          PSTRB  = 4'b0000;
          PWDATA = 32'h0;
        end
      endcase
    end
  end

endmodule
